// File: rtl/wb_ram_port_switch.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_port_switch
// Description : Owns the writable-port select for wb_openram_wrapper. On a
//               change of switch_req_i it blocks new Wishbone cycles on both
//               ports, drains in-flight cycles, toggles writable_port_req,
//               waits SETTLE_CYCLES, then reopens both ports. ACKs pass
//               through unchanged; CYC/STB are gated.
//               Optional drain timeout: define WB_PORT_SWITCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_port_switch #(
  parameter int SETTLE_CYCLES  = 2,    // 1..15
  parameter bit RESET_SEL      = 1'b0, // 0 = A writable, 1 = B writable
  parameter int TIMEOUT_CYCLES = 255   // 1..255, drain timeout
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic switch_req_i,
  input  logic wbs_a_cyc_i,
  input  logic wbs_a_stb_i,
  input  logic wbs_b_cyc_i,
  input  logic wbs_b_stb_i,
  output logic ram_a_cyc_o,
  output logic ram_a_stb_o,
  output logic ram_b_cyc_o,
  output logic ram_b_stb_o,
  input  logic ram_a_ack_i,
  input  logic ram_b_ack_i,
  output logic wbs_a_ack_o,
  output logic wbs_b_ack_o,
  output logic writable_port_req,
  output logic writable_port_sel,
  output logic switch_busy_o,
  output logic switch_err_o
);

  // One counter serves both the drain timeout and the settle period, so it
  // is sized for the larger of the two limits.
  localparam int C_CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  localparam logic [C_CNT_W-1:0] C_SETTLE_LAST = C_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE     = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT     = {C_CNT_W{1'b1}};
`ifdef WB_PORT_SWITCH_TIMEOUT_EN
  localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 sel_q, sel_d;
  logic                 infl_a_q, infl_a_d;
  logic                 infl_b_q, infl_b_d;
  logic                 infl_a_upd, infl_b_upd;
  logic                 open_w;
  logic                 gate_a, gate_b;
`ifdef WB_PORT_SWITCH_TIMEOUT_EN
  logic                 err_q, err_d;
`endif

  // Port gating: open only in IDLE, except a cycle already in flight may finish.
  always_comb begin
    open_w      = (state_q == ST_IDLE);
    gate_a      = open_w | infl_a_q;
    gate_b      = open_w | infl_b_q;
    ram_a_cyc_o = wbs_a_cyc_i & gate_a;
    ram_a_stb_o = wbs_a_stb_i & wbs_a_cyc_i & gate_a;
    ram_b_cyc_o = wbs_b_cyc_i & gate_b;
    ram_b_stb_o = wbs_b_stb_i & wbs_b_cyc_i & gate_b;
  end

  // ACKs are returned to the masters untouched.
  assign wbs_a_ack_o = ram_a_ack_i;
  assign wbs_b_ack_o = ram_b_ack_i;

  // Status outputs derived from the state register.
  assign writable_port_req = req_q;
  assign writable_port_sel = (state_q == ST_IDLE) ? req_q : sel_q;
  assign switch_busy_o     = (state_q != ST_IDLE);
`ifdef WB_PORT_SWITCH_TIMEOUT_EN
  assign switch_err_o      = err_q;
`else
  assign switch_err_o      = 1'b0;
`endif

  // In-flight tracking: an ACK or a dropped CYC ends the cycle; a forwarded
  // strobe that is not acked in the same cycle starts one.
  always_comb begin
    infl_a_upd = infl_a_q;
    infl_b_upd = infl_b_q;
    if (!wbs_a_cyc_i || ram_a_ack_i) begin
      infl_a_upd = 1'b0;
    end else if (ram_a_cyc_o && ram_a_stb_o) begin
      infl_a_upd = 1'b1;
    end
    if (!wbs_b_cyc_i || ram_b_ack_i) begin
      infl_b_upd = 1'b0;
    end else if (ram_b_cyc_o && ram_b_stb_o) begin
      infl_b_upd = 1'b1;
    end
  end

  // Next-state logic for the handover sequence IDLE -> DRAIN -> SWITCH -> SETTLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    sel_d    = (state_q == ST_IDLE) ? req_q : sel_q;
    infl_a_d = infl_a_upd;
    infl_b_d = infl_b_upd;
`ifdef WB_PORT_SWITCH_TIMEOUT_EN
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (switch_req_i != req_q) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (switch_req_i == req_q) begin
          // Request withdrawn before the toggle: abandon the handover.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!infl_a_upd && !infl_b_upd) begin
          // Uses the post-ACK flags so an ACK in this cycle lets us proceed.
          state_d = ST_SWITCH;
        end else begin
`ifdef WB_PORT_SWITCH_TIMEOUT_EN
          if (cnt_q == C_TIMEOUT_LAST) begin
            // Stuck cycle: drop it and switch anyway, flagging the event.
            state_d  = ST_SWITCH;
            infl_a_d = 1'b0;
            infl_b_d = 1'b0;
            err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
`else
          // Waits indefinitely; saturate so the count never wraps.
          if (cnt_q != C_CNT_SAT) begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
`endif
        end
      end

      ST_SWITCH: begin
        // Both ports are closed and empty here, so the select may move.
        req_d   = ~req_q;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, select and in-flight registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= RESET_SEL;
      sel_q    <= RESET_SEL;
      infl_a_q <= 1'b0;
      infl_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      infl_a_q <= infl_a_d;
      infl_b_q <= infl_b_d;
    end
  end

`ifdef WB_PORT_SWITCH_TIMEOUT_EN
  // Sticky drain-timeout flag, cleared only by reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_port_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ram_port_switch
// Description : Directed self-checking bench for wb_ram_port_switch
//               (SETTLE_CYCLES=2, RESET_SEL=0, TIMEOUT_CYCLES=8). The timeout
//               scenario runs when WB_PORT_SWITCH_TIMEOUT_EN is defined; the
//               default build checks the indefinite drain instead.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_port_switch;

  logic clk = 1'b0;
  logic rst;
  logic sw;
  logic a_cyc, a_stb, b_cyc, b_stb;
  logic ack_a, ack_b;
  logic ram_a_cyc, ram_a_stb, ram_b_cyc, ram_b_stb;
  logic wbs_a_ack, wbs_b_ack;
  logic req, sel, busy, err;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_ram_port_switch #(
    .SETTLE_CYCLES (2),
    .RESET_SEL     (1'b0),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .switch_req_i     (sw),
    .wbs_a_cyc_i      (a_cyc),
    .wbs_a_stb_i      (a_stb),
    .wbs_b_cyc_i      (b_cyc),
    .wbs_b_stb_i      (b_stb),
    .ram_a_cyc_o      (ram_a_cyc),
    .ram_a_stb_o      (ram_a_stb),
    .ram_b_cyc_o      (ram_b_cyc),
    .ram_b_stb_o      (ram_b_stb),
    .ram_a_ack_i      (ack_a),
    .ram_b_ack_i      (ack_b),
    .wbs_a_ack_o      (wbs_a_ack),
    .wbs_b_ack_o      (wbs_b_ack),
    .writable_port_req(req),
    .writable_port_sel(sel),
    .switch_busy_o    (busy),
    .switch_err_o     (err)
  );

  // Advance one clock edge and step just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw = 1'b0;
    a_cyc = 1'b0; a_stb = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_req",  req,  1'b0);
    chk("rst_sel",  sel,  1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err",  err,  1'b0);
    rst = 1'b0;
    tick();

    // Pass-through on an idle, open port A
    a_cyc = 1'b1; a_stb = 1'b1; #1;
    chk("pt_a_cyc", ram_a_cyc, 1'b1);
    chk("pt_a_stb", ram_a_stb, 1'b1);
    chk("pt_b_cyc", ram_b_cyc, 1'b0);
    ack_a = 1'b1; #1;
    chk("pt_a_ack", wbs_a_ack, 1'b1);
    chk("pt_b_ack", wbs_b_ack, 1'b0);
    tick();
    a_cyc = 1'b0; a_stb = 1'b0; ack_a = 1'b0;
    tick();

    // Idle-bus switch to B: request at edge N
    sw = 1'b1;
    tick(); // N+1 DRAIN
    chk("sw_n1_busy", busy, 1'b1);
    chk("sw_n1_req",  req,  1'b0);
    tick(); // N+2 SWITCH
    chk("sw_n2_busy", busy, 1'b1);
    chk("sw_n2_req",  req,  1'b0);
    tick(); // N+3 toggled, SETTLE
    chk("sw_n3_req",  req,  1'b1);
    chk("sw_n3_sel",  sel,  1'b0);
    chk("sw_n3_busy", busy, 1'b1);
    tick(); // N+4 SETTLE
    chk("sw_n4_busy", busy, 1'b1);
    tick(); // N+5 reopen
    chk("sw_n5_busy", busy, 1'b0);
    chk("sw_n5_sel",  sel,  1'b1);

    // Switch back to A while an A cycle stalls; B raised during drain
    a_cyc = 1'b1; a_stb = 1'b1; #1;
    chk("st_a_open", ram_a_stb, 1'b1);
    tick(); // E10: A in flight
    sw = 1'b0;
    tick(); // E11: DRAIN
    b_cyc = 1'b1; b_stb = 1'b1; #1;
    chk("st_b_cyc_blk", ram_b_cyc, 1'b0);
    chk("st_b_stb_blk", ram_b_stb, 1'b0);
    chk("st_a_infl",    ram_a_cyc, 1'b1);
    tick(); tick(); tick(); // E14
    chk("st_e14_busy", busy, 1'b1);
    chk("st_e14_req",  req,  1'b1);
    tick(); // E15: ACK driven
    ack_a = 1'b1; #1;
    chk("st_a_ack", wbs_a_ack, 1'b1);
    tick(); // E16: SWITCH
    chk("st_e16_req",   req,       1'b1);
    chk("st_e16_a_cyc", ram_a_cyc, 1'b0);
    a_cyc = 1'b0; a_stb = 1'b0; ack_a = 1'b0;
    tick(); // E17: toggled
    chk("st_e17_req",   req,       1'b0);
    chk("st_e17_b_stb", ram_b_stb, 1'b0);
    tick(); // E18
    chk("st_e18_b_stb", ram_b_stb, 1'b0);
    tick(); // E19: reopen
    chk("st_e19_busy",  busy,      1'b0);
    chk("st_e19_b_cyc", ram_b_cyc, 1'b1);
    chk("st_e19_b_stb", ram_b_stb, 1'b1);
    ack_b = 1'b1; #1;
    chk("st_b_ack", wbs_b_ack, 1'b1);
    tick();
    b_cyc = 1'b0; b_stb = 1'b0; ack_b = 1'b0;
    tick();

    // Abort: request withdrawn while A is in flight
    a_cyc = 1'b1; a_stb = 1'b1;
    tick(); // A in flight
    sw = 1'b1;
    tick(); // DRAIN
    chk("ab_busy1", busy, 1'b1);
    tick();
    chk("ab_busy2",  busy,      1'b1);
    chk("ab_a_infl", ram_a_cyc, 1'b1);
    sw = 1'b0;
    tick(); // back to IDLE
    chk("ab_busy3", busy, 1'b0);
    chk("ab_req",   req,  1'b0);
    chk("ab_sel",   sel,  1'b0);
    ack_a = 1'b1;
    tick();
    a_cyc = 1'b0; a_stb = 1'b0; ack_a = 1'b0;
    tick();
    chk("ab_req_late", req, 1'b0);

    // Reset during SETTLE
    sw = 1'b1;
    tick(); tick(); tick(); // SETTLE, toggled
    chk("rs_req1",  req,  1'b1);
    chk("rs_busy1", busy, 1'b1);
    a_cyc = 1'b1; a_stb = 1'b1; #1;
    chk("rs_a_blk", ram_a_cyc, 1'b0);
    rst = 1'b1; sw = 1'b0;
    tick();
    chk("rs_busy2", busy,      1'b0);
    chk("rs_req2",  req,       1'b0);
    chk("rs_a_open", ram_a_cyc, 1'b1);
    rst = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
    tick();

`ifdef WB_PORT_SWITCH_TIMEOUT_EN
    // B never acked: forced switch after 8 DRAIN cycles
    b_cyc = 1'b1; b_stb = 1'b1;
    tick(); // B in flight
    sw = 1'b1;
    tick(); // E2: DRAIN, count 0
    repeat (7) tick(); // E9: count 7
    chk("to_e9_busy",  busy,      1'b1);
    chk("to_e9_err",   err,       1'b0);
    chk("to_e9_req",   req,       1'b0);
    chk("to_e9_b_cyc", ram_b_cyc, 1'b1);
    tick(); // E10: SWITCH, forced
    chk("to_e10_err",   err,       1'b1);
    chk("to_e10_b_cyc", ram_b_cyc, 1'b0);
    chk("to_e10_req",   req,       1'b0);
    tick(); // E11
    chk("to_e11_req", req, 1'b1);
    tick(); tick(); // E13: reopen
    chk("to_e13_busy",  busy,      1'b0);
    chk("to_e13_err",   err,       1'b1);
    chk("to_e13_b_cyc", ram_b_cyc, 1'b1);
    b_cyc = 1'b0; b_stb = 1'b0;
    tick(); tick();
    chk("to_sticky", err, 1'b1);
    rst = 1'b1; sw = 1'b0;
    tick();
    chk("to_rst_err", err, 1'b0);
    rst = 1'b0;
    tick();
`else
    // No timeout: DRAIN holds while B stays in flight
    b_cyc = 1'b1; b_stb = 1'b1;
    tick();
    sw = 1'b1;
    repeat (20) tick();
    chk("nd_busy",  busy,      1'b1);
    chk("nd_req",   req,       1'b0);
    chk("nd_b_cyc", ram_b_cyc, 1'b1);
    chk("nd_err",   err,       1'b0);
    b_cyc = 1'b0; b_stb = 1'b0;
    tick(); // SWITCH
    chk("nd_sw_req", req, 1'b0);
    tick(); // toggled
    chk("nd_tg_req", req, 1'b1);
    tick(); tick();
    chk("nd_busy_end", busy, 1'b0);
    rst = 1'b1; sw = 1'b0;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
